// File: rtl/ps2_scancode_sequencer.sv
// PS/2 scancode sequencer: folds E0/F0 prefix bytes into {extended, release, code}
// events and buffers them in a small FIFO with a valid/ready interface.
module ps2_scancode_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          event_ready,
    input  logic                          clear_overflow,
    output logic                          event_valid,
    output logic [7:0]                    event_code,
    output logic                          event_extended,
    output logic                          event_release,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          seq_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0_F0} state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } event_t;

    state_t             state, next_state;
    logic               prev_valid, armed, accept;
    logic [TO_W-1:0]    to_cnt;
    logic               timeout;
    logic               emit, emit_ext, emit_rel, error;
    logic               is_e0, is_f0, is_bad;

    event_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full, push, pop, drop;
    event_t             head;

    // armed stays low after reset until byte_valid is seen low, so a level
    // that was already high across reset release is never taken as a new byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_valid <= 1'b0;
            armed      <= 1'b0;
        end else begin
            prev_valid <= byte_valid;
            if (!byte_valid) armed <= 1'b1;
        end
    end

    assign accept = byte_valid && !prev_valid && armed;
    assign is_e0  = (byte_data == 8'hE0);
    assign is_f0  = (byte_data == 8'hF0);
    assign is_bad = (byte_data == 8'h00) || (byte_data == 8'hFF);

    // An accepted byte wins over a timeout landing in the same cycle.
    assign timeout = (state != IDLE) && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                   to_cnt <= '0;
        else if (accept || state == IDLE || timeout) to_cnt <= '0;
        else                                         to_cnt <= to_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the comb blocks below use blocking with defaults.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (accept) begin
            if (is_bad) begin
                next_state = IDLE;
            end else begin
                case (state)
                    IDLE:      next_state = is_e0 ? GOT_E0 : (is_f0 ? GOT_F0 : IDLE);
                    GOT_E0:    next_state = is_f0 ? GOT_E0_F0 : (is_e0 ? GOT_E0 : IDLE);
                    GOT_F0:    next_state = is_e0 ? GOT_E0 : (is_f0 ? GOT_F0 : IDLE);
                    GOT_E0_F0: next_state = IDLE;
                    default:   next_state = IDLE;
                endcase
            end
        end else if (timeout) begin
            next_state = IDLE;
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        error    = timeout;
        if (accept) begin
            if (is_bad) begin
                error = 1'b1;
            end else begin
                case (state)
                    IDLE: emit = !is_e0 && !is_f0;
                    GOT_E0: begin
                        emit     = !is_e0 && !is_f0;
                        emit_ext = 1'b1;
                    end
                    GOT_F0: begin
                        error    = is_e0;
                        emit     = !is_e0 && !is_f0;
                        emit_rel = 1'b1;
                    end
                    GOT_E0_F0: begin
                        error    = is_e0 || is_f0;
                        emit     = !is_e0 && !is_f0;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) seq_error <= 1'b0;
        else       seq_error <= error;
    end

    // A push into a full FIFO is allowed when the head leaves on the same edge.
    assign event_valid = (fifo_count != '0);
    assign full        = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop         = event_valid && event_ready;
    assign push        = emit && (!full || pop);
    assign drop        = emit && full && !pop;

    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers define what is valid, and outputs are gated while empty.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{ext: emit_ext, rel: emit_rel, code: byte_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)               overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

    assign head           = mem[rd_ptr];
    assign event_code     = event_valid ? head.code : 8'h00;
    assign event_extended = event_valid && head.ext;
    assign event_release  = event_valid && head.rel;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Scoreboard bench for ps2_scancode_sequencer: expected events are queued as
// bytes are driven and compared in order as the consumer pops them.
module tb_ps2_scancode_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       event_ready = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       event_valid, event_extended, event_release, overflow, seq_error;
    logic [7:0] event_code;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int e0;
    logic [9:0] exp_q [$];

    ps2_scancode_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .event_ready(event_ready), .clear_overflow(clear_overflow),
        .event_valid(event_valid), .event_code(event_code),
        .event_extended(event_extended), .event_release(event_release),
        .fifo_count(fifo_count), .overflow(overflow), .seq_error(seq_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_event(input logic ext, input logic rel, input logic [7:0] code);
        exp_q.push_back({ext, rel, code});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1 byte_data = b; byte_valid = 1'b1;
        @(posedge clock); #1 byte_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && fifo_count != 0; i++) @(posedge clock);
        @(posedge clock); #1;
        check(tag, fifo_count, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Consumer side of the scoreboard: an accepted pop must match the oldest expectation.
    always @(negedge clock) begin
        if (seq_error) err_pulses++;
        if (!reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) check("spurious_event", exp_q.size(), 1);
            else check("event", {22'd0, event_extended, event_release, event_code},
                       {22'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        @(negedge clock);
        check("rst_valid", event_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_seq_error", seq_error, 0);
        check("rst_code", event_code, 0);
        @(posedge clock); #1 reset = 1'b0;
        event_ready = 1'b1;

        // Plain make, then break; one-cycle latency into an empty FIFO.
        expect_event(0, 0, 8'h1C);
        send_byte(8'h1C);
        check("lat_make_valid", event_valid, 1);
        check("lat_make_code", event_code, 8'h1C);
        send_byte(8'hF0);
        expect_event(0, 1, 8'h1C);
        send_byte(8'h1C);
        check("lat_break_valid", event_valid, 1);
        check("lat_break_rel", event_release, 1);
        wait_drain("drain_basic");

        // Extended make and extended break.
        expect_event(1, 0, 8'h75);
        send_byte(8'hE0); send_byte(8'h75);
        expect_event(1, 1, 8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        wait_drain("drain_ext");

        // Prefix repeats and protocol errors.
        e0 = err_pulses;
        expect_event(1, 0, 8'h1C);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'hE0);
        expect_event(1, 0, 8'h74);
        send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hE0);
        send_byte(8'h00);
        send_byte(8'hF0); send_byte(8'hFF);
        idle_cycle();
        check("proto_err_count", err_pulses - e0, 4);
        expect_event(0, 0, 8'h29);
        send_byte(8'h29);
        wait_drain("drain_err");

        // A held level is one byte; FF is an error and emits nothing.
        e0 = err_pulses;
        expect_event(0, 0, 8'h15);
        @(posedge clock); #1 byte_data = 8'h15; byte_valid = 1'b1;
        repeat (10) @(posedge clock);
        #1 byte_valid = 1'b0;
        wait_drain("drain_held");
        send_byte(8'hFF);
        idle_cycle();
        check("ff_no_event", event_valid, 0);
        check("ff_err_count", err_pulses - e0, 1);

        // Fill to overflow with the consumer stalled.
        event_ready = 1'b0;
        expect_event(0, 0, 8'h15); expect_event(0, 0, 8'h1D);
        expect_event(0, 0, 8'h24); expect_event(0, 0, 8'h2D);
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
        send_byte(8'h2D); send_byte(8'h2C);
        check("full_count", fifo_count, 4);
        check("full_overflow", overflow, 1);
        check("full_head", event_code, 8'h15);
        repeat (3) idle_cycle();
        check("stall_head_stable", event_code, 8'h15);

        // Clear and drop on the same edge: the drop wins.
        @(posedge clock); #1 byte_data = 8'h3C; byte_valid = 1'b1; clear_overflow = 1'b1;
        @(posedge clock); #1 byte_valid = 1'b0; clear_overflow = 1'b0;
        check("clear_vs_drop", overflow, 1);
        @(posedge clock); #1 clear_overflow = 1'b1;
        @(posedge clock); #1 clear_overflow = 1'b0;
        check("clear_overflow", overflow, 0);

        // Full FIFO with push and pop on the same edge.
        expect_event(0, 0, 8'h24);
        @(posedge clock); #1 byte_data = 8'h24; byte_valid = 1'b1; event_ready = 1'b1;
        @(posedge clock); #1 byte_valid = 1'b0; event_ready = 1'b0;
        check("full_pushpop_count", fifo_count, 4);
        check("full_pushpop_overflow", overflow, 0);
        check("full_pushpop_head", event_code, 8'h1D);
        event_ready = 1'b1;
        wait_drain("drain_full");

        // Timeout out of GOT_F0 fires exactly TMO cycles after the accept.
        send_byte(8'hF0);
        repeat (TMO - 1) @(posedge clock);
        @(negedge clock);
        check("tmo_early", seq_error, 0);
        @(negedge clock);
        check("tmo_pulse", seq_error, 1);
        @(negedge clock);
        check("tmo_one_cycle", seq_error, 0);
        expect_event(0, 0, 8'h35);
        send_byte(8'h35);
        wait_drain("drain_tmo");

        // Reset mid-sequence discards the E0 prefix.
        send_byte(8'hE0);
        #3 reset = 1'b1;
        #1 check("async_rst_count", fifo_count, 0);
        @(posedge clock); #1 reset = 1'b0;
        expect_event(0, 0, 8'h1C);
        send_byte(8'h1C);
        wait_drain("drain_rst");

        // A level held high across reset release is ignored until it re-rises.
        @(posedge clock); #1 reset = 1'b1; byte_data = 8'h2C; byte_valid = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        repeat (4) idle_cycle();
        check("held_rst_no_event", fifo_count, 0);
        byte_valid = 1'b0;
        expect_event(0, 0, 8'h2C);
        send_byte(8'h2C);
        wait_drain("drain_rerise");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_sequencer.md
PS2_SCANCODE_SEQUENCER -- requirements
Module: ps2_scancode_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, >= 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, clock cycles a prefix state may wait for its next byte.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port byte_valid  input  1  level from the PS/2 receiver; high while a checked byte is present.
REQ-006 Port byte_data  input  8  received byte; valid whenever byte_valid is high.
REQ-007 Port event_ready  input  1  consumer accepts the head event.
REQ-008 Port clear_overflow  input  1  synchronous clear of overflow.
REQ-009 Port event_valid  output  1  FIFO non-empty.
REQ-010 Port event_code  output  8  head event scancode.
REQ-011 Port event_extended  output  1  head event was preceded by E0.
REQ-012 Port event_release  output  1  head event was preceded by F0 (break).
REQ-013 Port fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 Port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-015 Port seq_error  output  1  one-cycle pulse on a protocol error or timeout.

Function
REQ-016 Byte acceptance: a byte is accepted only in a cycle where byte_valid is 1 and was 0 in the previous cycle (rising-edge detect, registered previous value); a held level is accepted once.
REQ-017 FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0_F0; transitions occur only on an accepted byte or a timeout.
REQ-018 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; any other code -> emit {ext=0, rel=0}, stay in IDLE.
REQ-019 GOT_E0: F0 -> GOT_E0_F0; E0 -> stay in GOT_E0; any other code -> emit {ext=1, rel=0}, go to IDLE.
REQ-020 GOT_F0: F0 -> stay in GOT_F0; E0 -> GOT_E0 with a seq_error pulse; any other code -> emit {ext=0, rel=1}, go to IDLE.
REQ-021 GOT_E0_F0: E0 or F0 -> IDLE with a seq_error pulse, nothing emitted; any other code -> emit {ext=1, rel=1}, go to IDLE.
REQ-022 Bytes 00 and FF in any state: nothing emitted, go to IDLE, pulse seq_error.
REQ-023 Timeout counter:
- cleared on every accepted byte and whenever the FSM is in IDLE;
- in any other state, increments each cycle;
- on reaching TIMEOUT_CYCLES-1: FSM goes to IDLE, seq_error pulses, nothing is emitted.
REQ-024 Emit writes {ext, rel, code} into the FIFO on the same clock edge that accepts the byte.
REQ-025 Latency: event_valid and the head fields are visible the cycle after acceptance when the FIFO was empty.
REQ-026 Handshake: a pop occurs on an edge with event_valid=1 and event_ready=1; the head fields hold stable while event_valid=1 and event_ready=0.
REQ-027 event_ready while empty has no effect; fifo_count never underflows.
REQ-028 Full FIFO:
- emit without a pop -> event dropped, overflow set to 1, fifo_count unchanged;
- emit with a pop in the same cycle -> both performed, no overflow, count unchanged.
REQ-029 Simultaneous emit and pop when not full: count unchanged; order preserved (FIFO, pointers wrap modulo FIFO_DEPTH).
REQ-030 overflow stays 1 until clear_overflow=1 or reset; if a clear and a new drop occur in the same cycle, overflow is 1.
REQ-031 event_code, event_extended and event_release are 0 while event_valid=0.

Reset
REQ-032 Reset asserted, independent of the clock:
- FSM goes to IDLE;
- FIFO is emptied;
- timeout counter and edge-detect register are cleared;
- event_valid, fifo_count, overflow and seq_error read 0.
REQ-033 Reset mid-sequence (for example after E0): the prefix is discarded, and the next byte 1C after release emits {ext=0, rel=0, 1C}.
REQ-034 A byte_valid level already high when reset releases is not accepted until it falls and rises again.

Verification
REQ-035 Bytes 1C; F0,1C -> two events {1C,0,0} then {1C,ext=0,rel=1}; each event_valid arrives 1 cycle after the accept.
REQ-036 Bytes E0,75; E0,F0,75 -> {75,ext=1,rel=0} then {75,ext=1,rel=1}.
REQ-037 event_ready=0, FIFO_DEPTH=4, five make codes 15,1D,24,2D,2C -> fifo_count=4, overflow=1, drain order 15,1D,24,2D.
REQ-038 Byte F0, then no byte for TIMEOUT_CYCLES cycles -> seq_error pulses once, FSM returns to IDLE; next byte 35 -> {35,0,0}.
REQ-039 FIFO full with event_ready=1, new byte 24 in the same cycle -> pop and push both occur, count stays 4, overflow stays 0.
REQ-040 byte_valid held high 10 cycles with byte 15 -> exactly one event; byte FF -> seq_error pulse, no event.
